// File: rtl/m16_pkg.sv
// Constants and fill-state encoding shared by the M16 serializer and its frame filler.
package m16_pkg;
  localparam int M16_ADDR_W     = 11;
  localparam int M16_WORD_W     = 12;
  localparam int M16_WORDS      = 2048;
  localparam int M16_MARKER_BIT = 11;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    DONE = 2'd2
  } fillState_t;
endpackage

// File: rtl/m16_frame_filler.sv
// Fills the bank of the M16 ping-pong frame RAM that M16 is not reading,
// padding on request and flagging bank swaps that arrive before the bank is full.
module m16_frame_filler
  import m16_pkg::*;
#(
  parameter int                ADDR_W   = M16_ADDR_W,
  parameter int                WORD_W   = M16_WORD_W,
  parameter logic [WORD_W-1:0] PAD_WORD = '0
) (
  input  logic              iClkOrb,
  input  logic              reset,
  input  logic              iSwitch,
  input  logic [WORD_W-2:0] iData,
  input  logic              iValid,
  output logic              oReady,
  input  logic              iFlush,
  output logic              oWrEn,
  output logic              oWrBank,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic [WORD_W-1:0] oWrData,
  output logic              oFull,
  output logic [ADDR_W:0]   oFillLvl,
  output logic              oUnderrun,
  output logic [7:0]        oUnderrunCnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LVL_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  // M16 ORs in the marker itself, so the top bit is always written as 0.
  localparam logic [WORD_W-1:0] PAD_CLEAN = {1'b0, PAD_WORD[WORD_W-2:0]};

  fillState_t        state, stateNext;
  logic [ADDR_W-1:0] addr, addrNext;
  logic              bank, bankNext;
  logic              swPrev;
  logic              swEdge, xfer;

  logic              readyNext, wrEnNext, wrBankNext, fullNext, underrunNext;
  logic [ADDR_W-1:0] wrAddrNext;
  logic [WORD_W-1:0] wrDataNext;
  logic [ADDR_W:0]   fillLvlNext;
  logic [7:0]        underrunCntNext;

  always_ff @(posedge iClkOrb or negedge reset) begin
    if (!reset) begin
      state        <= FILL;
      addr         <= '0;
      bank         <= 1'b1;
      swPrev       <= 1'b0;
      oReady       <= 1'b0;
      oWrEn        <= 1'b0;
      oWrBank      <= 1'b1;
      oWrAddr      <= '0;
      oWrData      <= '0;
      oFull        <= 1'b0;
      oFillLvl     <= '0;
      oUnderrun    <= 1'b0;
      oUnderrunCnt <= '0;
    end else begin
      state        <= stateNext;
      addr         <= addrNext;
      bank         <= bankNext;
      swPrev       <= iSwitch;
      oReady       <= readyNext;
      oWrEn        <= wrEnNext;
      oWrBank      <= wrBankNext;
      oWrAddr      <= wrAddrNext;
      oWrData      <= wrDataNext;
      oFull        <= fullNext;
      oFillLvl     <= fillLvlNext;
      oUnderrun    <= underrunNext;
      oUnderrunCnt <= underrunCntNext;
    end
  end

  always_comb begin
    swEdge          = iSwitch ^ swPrev;
    xfer            = iValid && oReady;
    stateNext       = state;
    addrNext        = addr;
    bankNext        = bank;
    wrEnNext        = 1'b0;
    wrBankNext      = oWrBank;
    wrAddrNext      = oWrAddr;
    wrDataNext      = oWrData;
    fillLvlNext     = oFillLvl;
    fullNext        = 1'b0;
    underrunNext    = 1'b0;
    underrunCntNext = oUnderrunCnt;

    if (swEdge) begin
      // A swap overrides everything, including a flush in the same cycle.
      stateNext   = FILL;
      bankNext    = ~iSwitch;
      addrNext    = '0;
      fillLvlNext = '0;
      if (state != DONE) begin
        underrunNext = 1'b1;
        if (oUnderrunCnt != 8'hFF) underrunCntNext = oUnderrunCnt + 8'd1;
      end
      if (xfer) begin
        wrEnNext    = 1'b1;
        wrBankNext  = ~iSwitch;
        wrAddrNext  = '0;
        wrDataNext  = {1'b0, iData};
        addrNext    = ADDR_ONE;
        fillLvlNext = LVL_ONE;
      end
    end else begin
      fullNext = (state == DONE);
      unique case (state)
        FILL: begin
          if (xfer) begin
            wrEnNext    = 1'b1;
            wrBankNext  = bank;
            wrAddrNext  = addr;
            wrDataNext  = {1'b0, iData};
            fillLvlNext = oFillLvl + LVL_ONE;
          end
          if (xfer && addr == LAST_ADDR) begin
            stateNext = DONE;
          end else begin
            if (xfer) addrNext = addr + ADDR_ONE;
            if (iFlush) stateNext = PAD;
          end
        end
        PAD: begin
          wrEnNext    = 1'b1;
          wrBankNext  = bank;
          wrAddrNext  = addr;
          wrDataNext  = PAD_CLEAN;
          fillLvlNext = oFillLvl + LVL_ONE;
          if (addr == LAST_ADDR) stateNext = DONE;
          else                   addrNext  = addr + ADDR_ONE;
        end
        default: ;
      endcase
    end

    readyNext = (stateNext == FILL);
  end

endmodule

// File: tb/tb_m16_frame_filler.sv
// Directed phases with random payload/valid/flush, every cycle checked against a word-count model.
module tb_m16_frame_filler;
  import m16_pkg::*;

  localparam logic [11:0] PAD     = 12'hABC;
  localparam logic [11:0] PAD_EXP = 12'h2BC;

  logic        iClkOrb = 1'b0;
  logic        reset   = 1'b1;
  logic        iSwitch = 1'b0;
  logic [10:0] iData   = '0;
  logic        iValid  = 1'b0;
  logic        iFlush  = 1'b0;
  logic        oReady, oWrEn, oWrBank, oFull, oUnderrun;
  logic [10:0] oWrAddr;
  logic [11:0] oWrData, oFillLvl;
  logic [7:0]  oUnderrunCnt;

  always #5 iClkOrb = ~iClkOrb;

  m16_frame_filler #(.ADDR_W(11), .WORD_W(12), .PAD_WORD(PAD)) dut (
    .iClkOrb(iClkOrb), .reset(reset), .iSwitch(iSwitch), .iData(iData),
    .iValid(iValid), .oReady(oReady), .iFlush(iFlush), .oWrEn(oWrEn),
    .oWrBank(oWrBank), .oWrAddr(oWrAddr), .oWrData(oWrData), .oFull(oFull),
    .oFillLvl(oFillLvl), .oUnderrun(oUnderrun), .oUnderrunCnt(oUnderrunCnt)
  );

  int testCount = 0;
  int failCount = 0;

  // Reference model: words held in the current bank, padding request, last swap level.
  logic [11:0] mCount;
  logic        mBank, mPadding, mPrevSw;
  logic        eReady, eWrEn, eWrBank, eFull, eUnderrun;
  logic [10:0] eWrAddr;
  logic [11:0] eWrData, eFillLvl;
  logic [7:0]  eCnt;

  int wrCount, dataMatch, padCount, urCount, cyc;
  int padFirst, padLast, padFirstAddr, padLastAddr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mCount = '0; mBank = 1'b1; mPadding = 1'b0; mPrevSw = 1'b0;
    eReady = 1'b0; eWrEn = 1'b0; eWrBank = 1'b1; eWrAddr = '0; eWrData = '0;
    eFull = 1'b0; eFillLvl = '0; eUnderrun = 1'b0; eCnt = '0;
  endtask

  task automatic modelWrite(input logic [11:0] d);
    eWrEn = 1'b1; eWrBank = mBank; eWrAddr = mCount[10:0]; eWrData = d;
    mCount = mCount + 12'd1;
  endtask

  task automatic modelCycle();
    logic swapped, accepted;
    swapped  = iSwitch ^ mPrevSw;
    mPrevSw  = iSwitch;
    accepted = iValid && eReady;
    eWrEn = 1'b0; eUnderrun = 1'b0;
    if (swapped) begin
      eUnderrun = (mCount < 12'd2048);
      if (eUnderrun && eCnt != 8'd255) eCnt = eCnt + 8'd1;
      mBank = ~iSwitch; mCount = '0; mPadding = 1'b0; eFull = 1'b0;
      if (accepted) modelWrite({1'b0, iData});
    end else begin
      eFull = (mCount == 12'd2048);
      if (mCount < 12'd2048) begin
        if (mPadding)      modelWrite({1'b0, PAD[10:0]});
        else if (accepted) modelWrite({1'b0, iData});
        if (iFlush) mPadding = 1'b1;
      end
    end
    eFillLvl = mCount;
    eReady   = (mCount < 12'd2048) && !mPadding;
  endtask

  task automatic sample(input string tag);
    chk(tag, 64'({oReady, oWrEn, oWrBank, oWrAddr, oWrData, oFull, oFillLvl, oUnderrun, oUnderrunCnt}),
             64'({eReady, eWrEn, eWrBank, eWrAddr, eWrData, eFull, eFillLvl, eUnderrun, eCnt}));
    if (oWrEn) begin
      wrCount++;
      if (oWrData == {1'b0, oWrAddr}) dataMatch++;
      if (oWrData == PAD_EXP) begin
        if (padCount == 0) begin padFirst = cyc; padFirstAddr = int'(oWrAddr); end
        padCount++;
        padLast = cyc; padLastAddr = int'(oWrAddr);
      end
    end
    if (oUnderrun) urCount++;
    cyc++;
  endtask

  task automatic step(input logic v, input logic [10:0] d, input logic f, input logic s);
    @(negedge iClkOrb);
    sample("cycle");
    iValid = v; iData = d; iFlush = f; iSwitch = s;
    modelCycle();
  endtask

  task automatic doReset();
    reset = 1'b0; iValid = 1'b0; iData = '0; iFlush = 1'b0; iSwitch = 1'b0;
    repeat (3) @(negedge iClkOrb);
    modelReset();
    sample("reset_state");
    reset = 1'b1;
    modelCycle();
  endtask

  task automatic fillTo(input int n, input logic s);
    int guard = 0;
    while (int'(mCount) < n && guard < 20000) begin
      step($urandom_range(0, 3) != 0, 11'($urandom), 1'b0, s);
      guard++;
    end
    chk("fill_bound", 64'(guard < 20000), 64'(1));
  endtask

  initial begin
    logic sw;
    int guard;
    wrCount = 0; dataMatch = 0; padCount = 0; urCount = 0; cyc = 0;
    padFirst = 0; padLast = 0; padFirstAddr = 0; padLastAddr = 0;
    #1;
    doReset();
    chk("reset_wrbank", 64'(oWrBank), 64'(1));
    chk("reset_ready", 64'(oReady), 64'(0));

    // Full bank of incrementing words
    wrCount = 0; dataMatch = 0;
    for (int i = 0; i < 2048; i++) step(1'b1, 11'(i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("last_wr_addr", 64'(oWrAddr), 64'(2047));
    chk("last_fill_lvl", 64'(oFillLvl), 64'(2048));
    chk("ready_after_last", 64'(oReady), 64'(0));
    step(1'b1, 11'h123, 1'b0, 1'b0);
    chk("full_after_last", 64'(oFull), 64'(1));
    step(1'b0, '0, 1'b0, 1'b0);
    chk("no_2049th_write", 64'(oWrEn), 64'(0));
    chk("full_write_count", 64'(wrCount), 64'(2048));
    chk("full_data_eq_addr", 64'(dataMatch), 64'(2048));
    $display("[TB] full fill: writes=%0d data_eq_addr=%0d", wrCount, dataMatch);

    // Swap while DONE, then an all-ones payload into the new bank
    sw = 1'b1;
    step(1'b0, '0, 1'b0, sw);
    step(1'b1, 11'h7FF, 1'b0, sw);
    chk("done_swap_underrun", 64'(oUnderrun), 64'(0));
    chk("done_swap_full", 64'(oFull), 64'(0));
    chk("done_swap_ready", 64'(oReady), 64'(1));
    step(1'b0, '0, 1'b0, sw);
    chk("marker_data", 64'(oWrData), 64'(12'h7FF));
    chk("marker_bank", 64'(oWrBank), 64'(0));
    $display("[TB] swap in done: wrData=%03h bank=%0d", oWrData, oWrBank);

    // Swap after 1000 words: underrun, edge-cycle word lands at addr 0 of new bank
    fillTo(1000, sw);
    sw = 1'b0;
    step(1'b1, 11'($urandom), 1'b0, sw);
    step(1'b0, '0, 1'b0, sw);
    chk("underrun_pulse", 64'(oUnderrun), 64'(1));
    chk("underrun_cnt_1", 64'(oUnderrunCnt), 64'(1));
    chk("edge_word_bank", 64'(oWrBank), 64'(1));
    chk("edge_word_addr", 64'(oWrAddr), 64'(0));
    chk("edge_word_en", 64'(oWrEn), 64'(1));
    $display("[TB] underrun swap: cnt=%0d bank=%0d addr=%0d", oUnderrunCnt, oWrBank, oWrAddr);

    // Flush after 100 words: pad 100..2047 back to back
    fillTo(100, sw);
    step(1'b0, '0, 1'b1, sw);
    padCount = 0; urCount = 0;
    guard = 0;
    while (!oFull && guard < 2200) begin
      step($urandom_range(0, 1) == 1, 11'($urandom), $urandom_range(0, 1) == 1, sw);
      guard++;
    end
    chk("pad_bound", 64'(guard < 2200), 64'(1));
    chk("pad_count", 64'(padCount), 64'(1948));
    chk("pad_contiguous", 64'(padLast - padFirst + 1), 64'(1948));
    chk("pad_first_addr", 64'(padFirstAddr), 64'(100));
    chk("pad_last_addr", 64'(padLastAddr), 64'(2047));
    chk("pad_no_underrun", 64'(urCount), 64'(0));
    $display("[TB] flush pad: pads=%0d addr %0d..%0d", padCount, padFirstAddr, padLastAddr);

    // 300 swaps, first one from DONE: 299 underruns, counter saturates
    urCount = 0;
    for (int i = 0; i < 300; i++) begin
      sw = ~sw;
      step($urandom_range(0, 1) == 1, 11'($urandom), $urandom_range(0, 1) == 1, sw);
    end
    step(1'b0, '0, 1'b0, sw);
    step(1'b0, '0, 1'b0, sw);
    chk("underrun_pulses", 64'(urCount), 64'(299));
    chk("underrun_sat", 64'(oUnderrunCnt), 64'(255));
    sw = ~sw;
    step(1'b0, '0, 1'b0, sw);
    step(1'b0, '0, 1'b0, sw);
    chk("underrun_held_pulse", 64'(oUnderrun), 64'(1));
    chk("underrun_held", 64'(oUnderrunCnt), 64'(255));
    $display("[TB] saturation: pulses=%0d cnt=%0d", urCount, oUnderrunCnt);

    // Asynchronous reset mid-fill
    fillTo(500, sw);
    #2 reset = 1'b0;
    #1;
    chk("async_wren", 64'(oWrEn), 64'(0));
    chk("async_ready", 64'(oReady), 64'(0));
    chk("async_fill", 64'(oFillLvl), 64'(0));
    chk("async_cnt", 64'(oUnderrunCnt), 64'(0));
    chk("async_bank", 64'(oWrBank), 64'(1));
    chk("async_addr_data", 64'({oWrAddr, oWrData, oFull, oUnderrun}), 64'(0));
    doReset();
    step(1'b1, 11'h155, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("post_reset_bank", 64'(oWrBank), 64'(1));
    chk("post_reset_addr", 64'(oWrAddr), 64'(0));
    chk("post_reset_data", 64'(oWrData), 64'(12'h155));
    chk("post_reset_cnt", 64'(oUnderrunCnt), 64'(0));
    $display("[TB] reset mid-fill: bank=%0d addr=%0d cnt=%0d", oWrBank, oWrAddr, oUnderrunCnt);

    for (int i = 0; i < 20; i++)
      step($urandom_range(0, 1) == 1, 11'($urandom), 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
